counter_run_ctrl: RTL and testbench
===================================

// Module: counter_run_ctrl
// PURPOSE
//  Scheduler and sequencer for the shared 8-bit up/down counter datapath.
//  Two requesters each submit a counting run (start value, end value, direction).
//  Runs are granted round-robin and driven onto the counter's control pins (load/value/up_down/enable).
//  A shadow copy of the count is kept, and completion is reported per run.
// PARAMETERS
//  WIDTH  8  counter / value width in bits
// PORTS
//  clk          in   1      single clock, all state updates on posedge
//  clear        in   1      reset: asynchronous, active-low
//  req0_valid   in   1      requester 0 has a run pending
//  req0_ready   out  1      requester 0 run accepted this cycle (valid&ready)
//  req0_start   in   WIDTH  requester 0 start value
//  req0_end     in   WIDTH  requester 0 end value
//  req0_up      in   1      requester 0 direction: 1=up, 0=down
//  req1_*       -    -      identical set for requester 1
//  abort        in   1      terminate the active run early
//  cnt_load     out  1      counter load strobe
//  cnt_value    out  WIDTH  counter load value
//  cnt_up_down  out  1      counter direction
//  cnt_en       out  1      counter step enable
//  count        out  WIDTH  shadow of the counter value
//  busy         out  1      state != IDLE
//  grant_id     out  1      owner of the current or last run
//  done         out  1      one-cycle run-complete pulse
//  done_id      out  1      owner of the completed run (valid with done)
//  done_aborted out  1      run ended by abort (valid with done)
// BEHAVIOUR
//  Reset and clocking:
//  - One clock; reset is asynchronous and active-low.
//  - clear=0 forces, immediately: state IDLE, count=0, all outputs 0, rr pointer favouring req0.
//  - Reset asserted mid-run abandons the run with no done pulse.
//  FSM states: IDLE, LOAD, RUN, DONE. Outputs are Moore-decoded from state and registered fields.
//  IDLE:
//  - Select one valid requester and assert only its reqN_ready; the other ready stays 0.
//  - On the handshake edge, capture start/end/up, set grant_id and go to LOAD.
//  - Ready is never asserted outside IDLE.
//  - Arbitration: if both requesters are valid, grant the one not granted last. If only one is valid, grant it.
//  LOAD (1 cycle):
//  - cnt_load=1, cnt_value=start, cnt_up_down=up.
//  - At the edge, count<=start.
//  - Next state is DONE if start==end, else RUN.
//  RUN:
//  - cnt_en=1, cnt_up_down=up.
//  - Each edge, count<=count+1 (up) or count-1 (down), modulo 2^WIDTH; 0xFF+1=0x00 and 0x00-1=0xFF are legal.
//  - When the updated count equals end, go to DONE.
//  - Run length d = (end-start) mod 2^WIDTH for up, (start-end) mod 2^WIDTH for down.
//  DONE (1 cycle):
//  - done=1, done_id=grant_id; next state IDLE.
//  - count holds its final value until the next LOAD.
//  Abort:
//  - abort=1 in LOAD or RUN goes to DONE next with done_aborted=1; count freezes (no step on that edge).
//  - If abort coincides with the edge where count reaches end (or LOAD with start==end), the run completes normally: done_aborted=0.
//  - abort is ignored in IDLE and DONE.
//  Outputs outside LOAD/RUN: cnt_load=0, cnt_en=0, cnt_value=0.
//  Latency:
//  - From the handshake edge, LOAD lasts 1 cycle, then RUN lasts d cycles, then done is high.
//  - A new request may be accepted the cycle after done (back-to-back gap = 1 IDLE cycle).
//  - A request whose valid drops before ready is not captured.
// TESTING
//  1 Reset: clear=0 while RUN at count=0x33 -> count=0, busy=0, done=0, cnt_* =0 without waiting for a clk edge.
//  2 req0 start=0x10 end=0x14 up=1 -> ready0 for 1 cycle, LOAD cnt_value=0x10, RUN count 11,12,13,14 (4 cycles), then done=1, done_id=0, done_aborted=0.
//  3 Wrap: req1 0xFE->0x01 up -> count FF,00,01 then done. Down 0x01->0xFE -> count 00,FF,FE then done.
//  4 Both valid, held high, each run 0x00->0x02 -> grants 0,1,0,1 (first after reset is 0), each separated by 1 IDLE cycle.
//  5 start=end=0x55 -> LOAD then done on the next cycle, cnt_en never 1.
//  6 Aborts:
//    - abort while count=0x12 (run 0x10->0x20) -> done, done_aborted=1, count stays 0x12.
//    - abort on the edge count reaches 0x20 -> done_aborted=0.

Source files
------------

// File: rtl/counter_run_ctrl.sv
// Round-robin scheduler/sequencer driving a shared up/down counter for two requesters.
// Handshake -> 1 LOAD cycle -> d RUN cycles -> 1 DONE cycle; ready only in IDLE, so requesters stall outside it.
module counter_run_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_start,
  input  logic [WIDTH-1:0] req0_end,
  input  logic             req0_up,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_start,
  input  logic [WIDTH-1:0] req1_end,
  input  logic             req1_up,
  input  logic             abort,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_value,
  output logic             cnt_up_down,
  output logic             cnt_en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             grant_id,
  output logic             done,
  output logic             done_id,
  output logic             done_aborted
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] end_q;
  logic             up_q;
  logic             aborted_q;
  logic             prefer1;
  logic             idle_ok;
  logic             pick1;
  logic             hs;
  logic [WIDTH-1:0] step_val;

  // Ready is held low while clear is asserted so every output reads 0 in reset.
  assign idle_ok    = (state == S_IDLE) & clear;
  assign pick1      = req1_valid & (~req0_valid | prefer1);
  assign req0_ready = idle_ok & req0_valid & ~pick1;
  assign req1_ready = idle_ok & pick1;
  assign hs         = req0_ready | req1_ready;
  assign step_val   = up_q ? count + ONE : count - ONE;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state     <= S_IDLE;
      start_q   <= '0;
      end_q     <= '0;
      up_q      <= 1'b0;
      aborted_q <= 1'b0;
      prefer1   <= 1'b0;
      grant_id  <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs) begin
            start_q   <= pick1 ? req1_start : req0_start;
            end_q     <= pick1 ? req1_end   : req0_end;
            up_q      <= pick1 ? req1_up    : req0_up;
            grant_id  <= pick1;
            prefer1   <= ~pick1;
            aborted_q <= 1'b0;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          count <= start_q;
          if (start_q == end_q) begin
            state <= S_DONE;
          end else if (abort) begin
            aborted_q <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // Reaching end wins over a coincident abort.
          if (step_val == end_q) begin
            count <= step_val;
            state <= S_DONE;
          end else if (abort) begin
            aborted_q <= 1'b1;
            state     <= S_DONE;
          end else begin
            count <= step_val;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cnt_load     = (state == S_LOAD);
  assign cnt_value    = (state == S_LOAD) ? start_q : '0;
  assign cnt_up_down  = ((state == S_LOAD) | (state == S_RUN)) & up_q;
  assign cnt_en       = (state == S_RUN);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign done_id      = (state == S_DONE) & grant_id;
  assign done_aborted = (state == S_DONE) & aborted_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Bench for counter_run_ctrl: per-run output schedules computed arithmetically, checked every cycle.
module tb_counter_run_ctrl;

  logic       clk = 1'b0;
  logic       clear;
  logic       req0_valid, req0_ready, req0_up;
  logic [7:0] req0_start, req0_end;
  logic       req1_valid, req1_ready, req1_up;
  logic [7:0] req1_start, req1_end;
  logic       abort;
  logic       cnt_load, cnt_up_down, cnt_en;
  logic [7:0] cnt_value, count;
  logic       busy, grant_id, done, done_id, done_aborted;

  always #5 clk = ~clk;

  counter_run_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .clear(clear),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_start(req0_start),
    .req0_end(req0_end), .req0_up(req0_up),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_start(req1_start),
    .req1_end(req1_end), .req1_up(req1_up),
    .abort(abort),
    .cnt_load(cnt_load), .cnt_value(cnt_value), .cnt_up_down(cnt_up_down), .cnt_en(cnt_en),
    .count(count), .busy(busy), .grant_id(grant_id),
    .done(done), .done_id(done_id), .done_aborted(done_aborted)
  );

  typedef struct packed {
    logic       load;
    logic [7:0] value;
    logic       ud;
    logic       en;
    logic [7:0] cnt;
    logic       busy;
    logic       gid;
    logic       done;
    logic       did;
    logic       dab;
  } obs_t;

  typedef struct packed {
    logic       v;
    logic [7:0] s;
    logic [7:0] e;
    logic       u;
  } req_t;

  obs_t       sched[$];   // expected outputs for each cycle of the current run
  int         idx = 0;
  logic [7:0] m_count = 8'h00;
  logic       m_gid = 1'b0;
  logic       m_pref1 = 1'b0;
  int         cur_abort = -1;
  int         next_abort = -1;
  logic       gnt_log[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  req_t       none = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t act_obs();
    return {cnt_load, cnt_value, cnt_up_down, cnt_en, count, busy, grant_id, done, done_id, done_aborted};
  endfunction

  function automatic obs_t idle_obs();
    return {1'b0, 8'h00, 1'b0, 1'b0, m_count, 1'b0, m_gid, 3'b000};
  endfunction

  function automatic obs_t done_obs(input logic [7:0] c, input logic g, input logic ab);
    return {1'b0, 8'h00, 1'b0, 1'b0, c, 1'b1, g, 1'b1, g, ab};
  endfunction

  function automatic req_t mk(input logic v, input logic [7:0] s, input logic [7:0] e, input logic u);
    req_t r;
    r.v = v; r.s = s; r.e = e; r.u = u;
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    logic [7:0] delta;
    r.v   = ($urandom_range(0, 2) != 0);
    r.s   = 8'($urandom);
    r.u   = 1'($urandom);
    delta = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
    r.e   = r.u ? r.s + delta : r.s - delta;
    return r;
  endfunction

  function automatic int run_cycles();
    int n = 0;
    foreach (sched[i]) if (sched[i].en) n++;
    return n;
  endfunction

  // Whole-run schedule: LOAD, then one RUN cycle per step, then DONE; j = planned abort cycle.
  task automatic build(input logic [7:0] s, input logic [7:0] e, input logic u, input logic g, input int j);
    logic [7:0] dd;
    logic [7:0] c;
    int d;
    sched.delete();
    idx = 0;
    dd = u ? e - s : s - e;
    d  = int'(dd);
    sched.push_back({1'b1, s, u, 1'b0, m_count, 1'b1, g, 3'b000});
    if (d == 0) begin sched.push_back(done_obs(s, g, 1'b0)); return; end
    if (j == 0) begin sched.push_back(done_obs(s, g, 1'b1)); return; end
    for (int k = 1; k <= d; k++) begin
      c = u ? s + 8'(k - 1) : s - 8'(k - 1);
      sched.push_back({1'b0, 8'h00, u, 1'b1, c, 1'b1, g, 3'b000});
      if (k == j && k < d) begin sched.push_back(done_obs(c, g, 1'b1)); return; end
    end
    sched.push_back(done_obs(e, g, 1'b0));
  endtask

  task automatic step(input req_t a, input req_t b, input logic stray);
    obs_t e;
    logic in_run, r0, r1, g;
    @(negedge clk);
    in_run = (sched.size() != 0);
    e = in_run ? sched[idx] : idle_obs();
    check("outputs", act_obs(), e);
    req0_valid = a.v; req0_start = a.s; req0_end = a.e; req0_up = a.u;
    req1_valid = b.v; req1_start = b.s; req1_end = b.e; req1_up = b.u;
    abort = (in_run && idx < sched.size() - 1) ? (idx == cur_abort) : stray;
    #1;
    r0 = !in_run && a.v && (!b.v || !m_pref1);
    r1 = !in_run && b.v && (!a.v || m_pref1);
    check("ready", {req0_ready, req1_ready}, {r0, r1});
    @(posedge clk);
    if (!in_run) begin
      if (r0 || r1) begin
        g = r1;
        gnt_log.push_back(g);
        cur_abort = next_abort;
        build(g ? b.s : a.s, g ? b.e : a.e, g ? b.u : a.u, g, cur_abort);
        m_gid   = g;
        m_pref1 = !g;
      end
    end else begin
      idx++;
      if (idx == sched.size()) begin
        m_count = sched[idx - 1].cnt;
        sched.delete();
        idx = 0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sched.size() != 0; i++) step(none, none, 1'($urandom));
    check("drain_timeout", sched.size(), 0);
    step(none, none, 1'($urandom));
  endtask

  initial begin
    clear = 1'b0; abort = 1'b0;
    req0_valid = 1'b0; req0_start = 8'h00; req0_end = 8'h00; req0_up = 1'b0;
    req1_valid = 1'b0; req1_start = 8'h00; req1_end = 8'h00; req1_up = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", act_obs(), 24'h0);
    check("reset_ready", {req0_ready, req1_ready}, 2'b00);
    @(negedge clk) clear = 1'b1;

    // Plain up run on requester 0.
    next_abort = -1;
    step(mk(1'b1, 8'h10, 8'h14, 1'b1), none, 1'b0);
    check("t2_len", sched.size(), 6);
    check("t2_runs", run_cycles(), 4);
    check("t2_first_step", sched[2].cnt, 8'h11);
    check("t2_final", sched[5], done_obs(8'h14, 1'b0, 1'b0));
    drain();

    // Wrap up and down on requester 1.
    step(none, mk(1'b1, 8'hFE, 8'h01, 1'b1), 1'b0);
    check("wrap_up_ff", sched[2].cnt, 8'hFF);
    check("wrap_up_00", sched[3].cnt, 8'h00);
    check("wrap_up_end", sched[4], done_obs(8'h01, 1'b1, 1'b0));
    drain();
    step(none, mk(1'b1, 8'h01, 8'hFE, 1'b0), 1'b0);
    check("wrap_dn_00", sched[2].cnt, 8'h00);
    check("wrap_dn_end", sched[4], done_obs(8'hFE, 1'b1, 1'b0));
    drain();

    // start==end with abort in LOAD still completes normally.
    next_abort = 0;
    step(mk(1'b1, 8'h55, 8'h55, 1'b1), none, 1'b0);
    check("eq_len", sched.size(), 2);
    check("eq_done", sched[1], done_obs(8'h55, 1'b0, 1'b0));
    drain();

    // Abort mid-run, then abort coinciding with the final step.
    next_abort = 3;
    step(mk(1'b1, 8'h10, 8'h20, 1'b1), none, 1'b0);
    check("abort_len", sched.size(), 5);
    check("abort_done", sched[4], done_obs(8'h12, 1'b0, 1'b1));
    drain();
    next_abort = 16;
    step(mk(1'b1, 8'h10, 8'h20, 1'b1), none, 1'b0);
    check("abort_late_len", sched.size(), 18);
    check("abort_late_done", sched[17], done_obs(8'h20, 1'b0, 1'b0));
    drain();

    // Asynchronous reset mid-run at count 0x33.
    next_abort = -1;
    step(mk(1'b1, 8'h30, 8'h40, 1'b1), none, 1'b0);
    repeat (4) step(none, none, 1'b0);
    @(negedge clk);
    check("pre_reset_count", count, 8'h33);
    #2 clear = 1'b0;
    #1;
    check("async_reset", act_obs(), 24'h0);
    check("async_reset_ready", {req0_ready, req1_ready}, 2'b00);
    sched.delete(); idx = 0; m_count = 8'h00; m_gid = 1'b0; m_pref1 = 1'b0;
    @(posedge clk);
    @(negedge clk) clear = 1'b1;

    // Both requesters held valid: grants alternate starting with 0.
    gnt_log.delete();
    for (int i = 0; i < 80 && gnt_log.size() < 4; i++)
      step(mk(1'b1, 8'h00, 8'h02, 1'b1), mk(1'b1, 8'h00, 8'h02, 1'b1), 1'b0);
    check("arb_count", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check("arb_grant", (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'd2, 32'(i % 2));
    drain();

    // Randomized traffic with planned aborts and ignored stray aborts.
    for (int i = 0; i < 4000; i++) begin
      next_abort = ($urandom_range(0, 1) != 0) ? -1 : int'($urandom_range(0, 8));
      step(rnd_req(), rnd_req(), ($urandom_range(0, 3) == 0));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
